// File: rtl/ascon_enc_host_drv.sv
`default_nettype none
// ascon_enc_host_drv: host driver/collector for the byte-serial three-lane Ascon encryption core.
// Rev 1.0. Optional tag comparator enabled by defining ASCON_HOST_TAG_CHECK_EN.
module ascon_enc_host_drv #(
  parameter int K       = 128,
  parameter int L       = 80,
  parameter int Y       = 80,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid_i,
  output logic           cmd_ready_o,
  input  logic [K-1:0]   key_i,
  input  logic [127:0]   nonce_i,
  input  logic [L-1:0]   ad_i,
  input  logic [Y-1:0]   pt_i,
  input  logic [135:0]   rnd_i,
`ifdef ASCON_HOST_TAG_CHECK_EN
  input  logic [127:0]   exp_tag_i,
  output logic           tag_ok_o,
`endif
  output logic           core_rst_o,
  output logic [23:0]    key_o,
  output logic [23:0]    nonce_o,
  output logic [23:0]    ad_o,
  output logic [23:0]    pt_o,
  output logic [55:0]    r64_o,
  output logic [7:0]     r128_o,
  output logic [7:0]     rpt_o,
  output logic           enc_start_o,
  input  logic           enc_ready_i,
  input  logic [7:0]     ct_byte_i,
  input  logic [7:0]     tag_byte_i,
  output logic           res_valid_o,
  input  logic           res_ready_i,
  output logic [Y-1:0]   ct_o,
  output logic [127:0]   tag_o,
  output logic           err_o
);

  localparam int MAX_A   = (K > 128) ? K : 128;
  localparam int MAX_B   = (MAX_A > L) ? MAX_A : L;
  localparam int MAX_BIT = (MAX_B > Y) ? MAX_B : Y;
  localparam int N_LOAD  = MAX_BIT / 8 + 1;
  localparam int N_OUT   = (Y / 8 > 16) ? Y / 8 : 16;
  localparam int CNT_A   = (N_LOAD > N_OUT) ? N_LOAD : N_OUT;
  localparam int CNT_MAX = (CNT_A > TIMEOUT) ? CNT_A : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] KB        = CW'(K / 8);
  localparam logic [CW-1:0] NB        = CW'(16);
  localparam logic [CW-1:0] LB        = CW'(L / 8);
  localparam logic [CW-1:0] YB        = CW'(Y / 8);
  localparam logic [CW-1:0] R64B      = CW'(8);
  localparam logic [CW-1:0] LOAD_LAST = CW'(N_LOAD - 1);
  localparam logic [CW-1:0] OUT_LAST  = CW'(N_OUT - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CRST    = 3'd1,
    S_LOAD    = 3'd2,
    S_START   = 3'd3,
    S_WAIT    = 3'd4,
    S_COLLECT = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [K-1:0]    key_reg;
  logic [127:0]    nonce_reg;
  logic [L-1:0]    ad_reg;
  logic [Y-1:0]    pt_reg;
  logic [Y-1:0]    ct_reg;
  logic [127:0]    tag_reg;
  logic            err_reg;

  // Shifting by the byte index puts the current MSB-first byte at the top.
  logic [K-1:0]    key_sh;
  logic [127:0]    nonce_sh;
  logic [L-1:0]    ad_sh;
  logic [Y-1:0]    pt_sh;

  assign key_sh   = key_reg   << {cnt, 3'b000};
  assign nonce_sh = nonce_reg << {cnt, 3'b000};
  assign ad_sh    = ad_reg    << {cnt, 3'b000};
  assign pt_sh    = pt_reg    << {cnt, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    cmd_ready_o = 1'b0;
    core_rst_o  = rst;
    enc_start_o = 1'b0;
    res_valid_o = 1'b0;
    key_o       = '0;
    nonce_o     = '0;
    ad_o        = '0;
    pt_o        = '0;
    r64_o       = '0;
    r128_o      = '0;
    rpt_o       = '0;
    case (state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) next_state = S_CRST;
      end
      S_CRST: begin
        core_rst_o = 1'b1;
        next_state = S_LOAD;
      end
      S_LOAD: begin
        // The final cycle has cnt past every length, so it is all zeros.
        if (cnt < KB)   key_o   = {rnd_i[15:0],  key_sh[K-1 -: 8]};
        if (cnt < NB)   nonce_o = {rnd_i[31:16], nonce_sh[127 -: 8]};
        if (cnt < LB)   ad_o    = {rnd_i[47:32], ad_sh[L-1 -: 8]};
        if (cnt < YB)   pt_o    = {rnd_i[63:48], pt_sh[Y-1 -: 8]};
        if (cnt < R64B) r64_o   = rnd_i[119:64];
        if (cnt < NB)   r128_o  = rnd_i[127:120];
        if (cnt < YB)   rpt_o   = rnd_i[135:128];
        if (cnt == LOAD_LAST) next_state = S_START;
      end
      S_START: begin
        enc_start_o = 1'b1;
        next_state  = S_WAIT;
      end
      S_WAIT: begin
        if (enc_ready_i)         next_state = S_COLLECT;
        else if (cnt == TO_LAST) next_state = S_DONE;
      end
      S_COLLECT: begin
        if (cnt == OUT_LAST) next_state = S_DONE;
      end
      S_DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      key_reg   <= '0;
      nonce_reg <= '0;
      ad_reg    <= '0;
      pt_reg    <= '0;
      ct_reg    <= '0;
      tag_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            key_reg   <= key_i;
            nonce_reg <= nonce_i;
            ad_reg    <= ad_i;
            pt_reg    <= pt_i;
            ct_reg    <= '0;
            tag_reg   <= '0;
            err_reg   <= 1'b0;
            cnt       <= '0;
          end
        end
        S_CRST:  cnt <= '0;
        S_LOAD:  cnt <= (cnt == LOAD_LAST) ? '0 : cnt + 1'b1;
        S_START: cnt <= '0;
        S_WAIT: begin
          if (enc_ready_i) begin
            cnt <= '0;
          end else if (cnt == TO_LAST) begin
            err_reg <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_COLLECT: begin
          // LSB-first streams: shifting in from the top lands byte 0 at [7:0].
          if (cnt < YB) ct_reg  <= {ct_byte_i, ct_reg[Y-1:8]};
          if (cnt < NB) tag_reg <= {tag_byte_i, tag_reg[127:8]};
          cnt <= (cnt == OUT_LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ct_o  = ct_reg;
  assign tag_o = tag_reg;
  assign err_o = err_reg;

`ifdef ASCON_HOST_TAG_CHECK_EN
  logic [127:0] exp_tag_reg;

  always_ff @(posedge clk) begin
    if (rst)                                exp_tag_reg <= '0;
    else if (state == S_IDLE && cmd_valid_i) exp_tag_reg <= exp_tag_i;
  end

  assign tag_ok_o = (state == S_DONE) && !err_reg && (tag_reg == exp_tag_reg);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascon_enc_host_drv.sv
`default_nettype none
// tb_ascon_enc_host_drv: scoreboard bench with a stub core for ascon_enc_host_drv.
module tb_ascon_enc_host_drv;
  localparam int K = 128, L = 80, Y = 80, TO = 4096;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid_i, cmd_ready_o;
  logic [K-1:0] key_i;
  logic [127:0] nonce_i;
  logic [L-1:0] ad_i;
  logic [Y-1:0] pt_i;
  logic [135:0] rnd_i;
  logic core_rst_o, enc_start_o, enc_ready_i;
  logic [23:0] key_o, nonce_o, ad_o, pt_o;
  logic [55:0] r64_o;
  logic [7:0] r128_o, rpt_o, ct_byte_i, tag_byte_i;
  logic res_valid_o, res_ready_i, err_o;
  logic [Y-1:0] ct_o;
  logic [127:0] tag_o;
  logic [127:0] exp_tag_drv;
`ifdef ASCON_HOST_TAG_CHECK_EN
  logic [127:0] exp_tag_i;
  logic tag_ok_o;
  assign exp_tag_i = exp_tag_drv;
`endif

  ascon_enc_host_drv #(.K(K), .L(L), .Y(Y), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i), .pt_i(pt_i), .rnd_i(rnd_i),
`ifdef ASCON_HOST_TAG_CHECK_EN
    .exp_tag_i(exp_tag_i), .tag_ok_o(tag_ok_o),
`endif
    .core_rst_o(core_rst_o), .key_o(key_o), .nonce_o(nonce_o), .ad_o(ad_o), .pt_o(pt_o),
    .r64_o(r64_o), .r128_o(r128_o), .rpt_o(rpt_o), .enc_start_o(enc_start_o),
    .enc_ready_i(enc_ready_i), .ct_byte_i(ct_byte_i), .tag_byte_i(tag_byte_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .ct_o(ct_o), .tag_o(tag_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] k, n, a, p;
    logic [55:0] r64;
    logic [7:0]  r128, rpt;
  } ld_t;

  typedef struct {
    logic [Y-1:0] ct;
    logic [127:0] tag;
    logic         err;
    int           lat;
    logic         ok;
  } res_t;

  ld_t  ldq[$];
  res_t resq[$];
  int total = 0, bad = 0;
  int cyc = 0, last_start = 0;
  logic stub_on = 1'b0, stub_drop = 1'b0;
  logic [7:0] ctb = 8'h00, tgb = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_load(input logic [7:0] kb, ks, nb, ab, pb,
                           input logic [15:0] lk, ln, la, lp,
                           input logic [55:0] r64, input logic [7:0] r128, rpt);
    for (int t = 0; t < 17; t++) begin
      ld_t e;
      e.k    = (t < 16) ? {lk, 8'(kb + ks * t)} : 24'h0;
      e.n    = (t < 16) ? {ln, 8'(nb + t)} : 24'h0;
      e.a    = (t < 10) ? {la, 8'(ab + t)} : 24'h0;
      e.p    = (t < 10) ? {lp, 8'(pb + t)} : 24'h0;
      e.r64  = (t < 8)  ? r64 : 56'h0;
      e.r128 = (t < 16) ? r128 : 8'h0;
      e.rpt  = (t < 10) ? rpt : 8'h0;
      ldq.push_back(e);
    end
  endtask

  task automatic push_res(input logic [Y-1:0] ct, input logic [127:0] tag,
                          input logic err, input int lat, input logic ok);
    res_t r;
    r.ct = ct; r.tag = tag; r.err = err; r.lat = lat; r.ok = ok;
    resq.push_back(r);
  endtask

  task automatic issue(input logic [127:0] k, n, input logic [79:0] a, p,
                       input logic [135:0] r, input logic [127:0] et);
    @(posedge clk); #1;
    key_i = k; nonce_i = n; ad_i = a; pt_i = p; rnd_i = r; exp_tag_drv = et;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    chk("cmd_ready before accept", cmd_ready_o, 1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic finish_job(input int budget, input logic early);
    int n = 0;
    if (early) res_ready_i = 1'b1;
    while (!res_valid_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid_o) begin
      total++; bad++;
      $display("FAIL result wait: no res_valid_o within %0d cycles", budget);
      res_ready_i = 1'b0;
      return;
    end
    if (!early) begin
      repeat (3) @(posedge clk);
      #1 res_ready_i = 1'b1;
    end
    @(posedge clk); #1 res_ready_i = 1'b0;
    @(negedge clk);
    chk("done exit", res_valid_o, 0);
  endtask

  // Stub core: ready 20 cycles after start, then byte n presented for COLLECT edge n.
  initial begin
    enc_ready_i = 1'b0; ct_byte_i = 8'h00; tag_byte_i = 8'h00;
    forever begin
      @(negedge clk);
      if (enc_start_o && !rst && stub_on) begin
        repeat (20) @(posedge clk);
        #1 enc_ready_i = 1'b1; ct_byte_i = ctb; tag_byte_i = tgb;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
          #1;
          ct_byte_i  = (k < 10) ? 8'(ctb + k) : 8'hEE;
          tag_byte_i = 8'(tgb + k);
          if (stub_drop) enc_ready_i = 1'b0;
          @(posedge clk);
        end
        #1 enc_ready_i = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (enc_start_o && !rst) last_start = cyc;
    end
  end

  // Load monitor: after each core reset pulse, check the 17 LOAD cycles and the start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (core_rst_o && !rst && ldq.size() >= 17) begin
        for (int t = 0; t < 17; t++) begin
          ld_t e;
          @(negedge clk);
          e = ldq.pop_front();
          if (t == 0) chk("core_rst single cycle", core_rst_o, 0);
          chk($sformatf("load cycle %0d", t),
              {key_o, nonce_o, ad_o, pt_o, r64_o, r128_o, rpt_o, enc_start_o},
              {e.k, e.n, e.a, e.p, e.r64, e.r128, e.rpt, 1'b0});
        end
        @(negedge clk);
        chk("start after last load", enc_start_o, 1);
      end
    end
  end

  // Result monitor: pops the scoreboard at every result handshake.
  initial begin
    logic prev_v;
    int first_v;
    prev_v = 1'b0; first_v = 0;
    forever begin
      @(negedge clk);
      if (rst) prev_v = 1'b0;
      else begin
        if (res_valid_o && !prev_v) first_v = cyc;
        prev_v = res_valid_o;
        if (res_valid_o && res_ready_i) begin
          if (resq.size() == 0) begin
            total++; bad++;
            $display("FAIL result: unexpected result ct=%h", ct_o);
          end else begin
            res_t r;
            r = resq.pop_front();
            chk("result ct", ct_o, r.ct);
            chk("result tag", tag_o, r.tag);
            chk("result err", err_o, r.err);
            chk("result latency from start", first_v - last_start, r.lat);
`ifdef ASCON_HOST_TAG_CHECK_EN
            chk("tag_ok", tag_ok_o, r.ok);
`endif
          end
        end
      end
    end
  end

  localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NON1 = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [79:0]  AD1  = 80'h20212223242526272829;
  localparam logic [79:0]  PT1  = 80'h30313233343536373839;
  localparam logic [127:0] KEY2 = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [79:0]  AD2  = 80'hC0C1C2C3C4C5C6C7C8C9;
  localparam logic [79:0]  PT2  = 80'hD0D1D2D3D4D5D6D7D8D9;
  localparam logic [135:0] RND1 = {136{1'b1}};
  localparam logic [135:0] RND2 = 136'h504F4E4D4C4B4A49484746454443424140;
  localparam logic [79:0]  CT1  = 80'hA9A8A7A6A5A4A3A2A1A0;
  localparam logic [127:0] TAG1 = 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0;
  localparam logic [79:0]  CT2  = 80'h69686766656463626160;
  localparam logic [127:0] TAG2 = 128'h7F7E7D7C7B7A79787776757473727170;

  initial begin
    rst = 1'b1; cmd_valid_i = 1'b0; res_ready_i = 1'b0;
    key_i = '0; nonce_i = '0; ad_i = '0; pt_i = '0; rnd_i = '0; exp_tag_drv = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset core_rst", core_rst_o, 1);
    chk("reset ctrl {ready,valid,err,start}", {cmd_ready_o, res_valid_o, err_o, enc_start_o}, 4'b1000);
    chk("reset results", {ct_o, tag_o}, 0);
    chk("reset lanes", {key_o, nonce_o, ad_o, pt_o, r64_o, r128_o, rpt_o}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("core_rst after reset", core_rst_o, 0);

    // Job 1: all-ones randomness, late res_ready, stray command during WAIT.
    stub_on = 1'b1; stub_drop = 1'b0; ctb = 8'hA0; tgb = 8'hB0;
    push_load(8'h00, 8'h01, 8'h10, 8'h20, 8'h30, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
              56'hFFFFFFFFFFFFFF, 8'hFF, 8'hFF);
    push_res(CT1, TAG1, 1'b0, 37, 1'b1);
    issue(KEY1, NON1, AD1, PT1, RND1, TAG1);
    repeat (24) @(posedge clk);
    #1 key_i = KEY2; cmd_valid_i = 1'b1;
    @(posedge clk); #1 cmd_valid_i = 1'b0;
    finish_job(200, 1'b0);

    // Job 2: distinct randomness bytes, ready drops during COLLECT, res_ready held high.
    stub_drop = 1'b1; ctb = 8'h60; tgb = 8'h70;
    push_load(8'hFF, 8'hEF, 8'h10, 8'hC0, 8'hD0, 16'h4140, 16'h4342, 16'h4544, 16'h4746,
              56'h4E4D4C4B4A4948, 8'h4F, 8'h50);
    push_res(CT2, TAG2, 1'b0, 37, 1'b0);
    issue(KEY2, NON1, AD2, PT2, RND2, TAG2 ^ 128'h1);
    finish_job(200, 1'b1);

    // Job 3: core never ready -> timeout.
    stub_on = 1'b0;
    push_res('0, '0, 1'b1, TO + 1, 1'b0);
    issue(KEY1, NON1, AD1, PT1, RND1, '0);
    finish_job(TO + 200, 1'b0);

    // Job 4: new command clears err, then reset during LOAD cycle 5.
    issue(KEY1, NON1, AD1, PT1, RND1, '0);
    @(negedge clk);
    chk("err cleared by new cmd", err_o, 0);
    chk("core_rst in CRST", core_rst_o, 1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("core_rst during rst", core_rst_o, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("after mid-job rst {ready,valid,core_rst}", {cmd_ready_o, res_valid_o, core_rst_o}, 3'b100);
    chk("lanes idle after rst", {key_o, pt_o, r64_o}, 0);

    // Job 5: normal job after the aborted one.
    stub_on = 1'b1; stub_drop = 1'b0; ctb = 8'hA0; tgb = 8'hB0;
    push_load(8'h00, 8'h01, 8'h10, 8'h20, 8'h30, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
              56'hFFFFFFFFFFFFFF, 8'hFF, 8'hFF);
    push_res(CT1, TAG1, 1'b0, 37, 1'b1);
    issue(KEY1, NON1, AD1, PT1, RND1, TAG1);
    finish_job(200, 1'b0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("result queue drained", resq.size(), 0);
    chk("load queue drained", ldq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
